// File: rtl/bhg_jt49_vol_seq.sv
// ----------------------------------------------------------------------------
// bhg_jt49_vol_seq
//   Multi-channel PSG volume exponent stage. Converts CHANNELS packed 5-bit
//   YM2149 log levels into linear DAC codes on a 1.5 dB/step curve. It uses one
//   shared registered LUT that scans one channel per clock. It also applies
//   per-channel slew limiting so that volume steps do not produce zipper noise.
//
//   A pass is IDLE -> SCAN (CHANNELS+1 clocks) -> DONE, so a cen sampled at
//   cycle 0 produces dout/dout_valid at cycle CHANNELS+2. A cen that arrives
//   while a pass is running (including the DONE cycle) is remembered in a
//   single sticky pending flag. That flag is serviced straight out of DONE.
//
// Parameters
//   DAC_BITS  output code width per channel (8..14)
//   CHANNELS  number of channels (1..16)
//   SLEW      max code change per channel per pass; 0 = jump to target
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   cen         sample strobe, requests one conversion pass
//   din         packed levels, channel k at [5k+4:5k]
//   busy        pass in progress
//   dout        packed linear codes, channel k at [DAC_BITS*(k+1)-1:DAC_BITS*k]
//   dout_valid  one-clock pulse when dout updates
//   mix         (BHG_JT49_VOL_MIX_EN only) unsigned sum of the committed codes,
//               updated together with dout
//
// Configuration macro: BHG_JT49_VOL_MIX_EN adds the mix output and its adder.
// ----------------------------------------------------------------------------
module bhg_jt49_vol_seq #(
    parameter int DAC_BITS = 8,
    parameter int CHANNELS = 3,
    parameter int SLEW     = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cen,
    input  logic [CHANNELS*5-1:0]          din,
    output logic                           busy,
    output logic [CHANNELS*DAC_BITS-1:0]   dout,
    output logic                           dout_valid
`ifdef BHG_JT49_VOL_MIX_EN
    ,
    output logic [DAC_BITS+$clog2(CHANNELS+1)-1:0] mix
`endif
);

    if (DAC_BITS < 8 || DAC_BITS > 14) begin : g_bad_dac_bits
        $error("bhg_jt49_vol_seq: DAC_BITS must be in 8..14");
    end
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("bhg_jt49_vol_seq: CHANNELS must be in 1..16");
    end

    localparam int IDX_W = $clog2(CHANNELS + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(CHANNELS);

    // A step at least as large as the widest possible move is the same as no limit.
    localparam logic [DAC_BITS:0] SLEW_LIM =
        (SLEW <= 0 || SLEW >= (2 ** DAC_BITS) - 1) ? '0 : (DAC_BITS + 1)'(SLEW);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    // ------------------------------------------------------------------
    // Elaboration-time volume table
    // ------------------------------------------------------------------
    function automatic logic [DAC_BITS-1:0] lut_calc(input int k);
        real full;
        real v;
        if (k == 0) return '0;
        full = real'((2 ** DAC_BITS) - 1);
        v    = full * (10.0 ** (-(real'(31 - k)) * 1.5 / 20.0));
        return DAC_BITS'($rtoi(v + 0.5));
    endfunction

    logic [DAC_BITS-1:0] lut [32];

    for (genvar k = 0; k < 32; k++) begin : g_lut
        localparam logic [DAC_BITS-1:0] LUT_VAL = lut_calc(k);
        assign lut[k] = LUT_VAL;
    end

    // ------------------------------------------------------------------
    // Slew limiter. The extra bit keeps the +/- step free of wrap-around.
    // The step is only taken when |d| > SLEW, so the result cannot overshoot.
    // ------------------------------------------------------------------
    function automatic logic [DAC_BITS-1:0] slew_step(input logic [DAC_BITS-1:0] cur,
                                                      input logic [DAC_BITS-1:0] tgt);
        logic [DAC_BITS:0] c;
        logic [DAC_BITS:0] t;
        logic [DAC_BITS:0] d;
        logic [DAC_BITS:0] r;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        d = (t >= c) ? (t - c) : (c - t);
        if (SLEW_LIM == '0 || d <= SLEW_LIM) r = t;
        else if (t > c)                      r = c + SLEW_LIM;
        else                                 r = c - SLEW_LIM;
        return r[DAC_BITS-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pend_q, pend_d;
    logic             snap;       // load din into the shadow register
    logic             s1_load;    // launch channel idx_q into the LUT stage
    logic             commit;     // publish the slewed values

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        snap    = 1'b0;
        s1_load = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cen || pend_q) begin
                    snap    = 1'b1;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (cen) pend_d = 1'b1;
                // idx_q == LAST is the extra clock that drains stage 2.
                if (idx_q == LAST) begin
                    state_d = DONE;
                end else begin
                    s1_load = 1'b1;
                    idx_d   = idx_q + 1'b1;
                end
            end
            DONE: begin
                commit = 1'b1;
                // A cen landing in this very cycle counts as pending.
                if (cen || pend_q) begin
                    snap    = 1'b1;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    // ------------------------------------------------------------------
    // Shadow register and LUT stage
    // ------------------------------------------------------------------
    logic [4:0]          shadow [CHANNELS];
    logic [4:0]          lvl;
    logic [DAC_BITS-1:0] lut_q;
    logic [IDX_W-1:0]    s1_ch;
    logic                s1_vld;

    always_comb begin
        lvl = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(idx_q) == k) lvl = shadow[k];
        end
    end

    // NOTE: the shadow register and the stage-1 data need no reset. Every use of them is qualified by a reset control bit (snap/s1_vld).
    always_ff @(posedge clk) begin
        if (snap) begin
            for (int k = 0; k < CHANNELS; k++) shadow[k] <= din[5*k +: 5];
        end
        if (s1_load) begin
            lut_q <= lut[lvl];
            s1_ch <= idx_q;
        end
    end

    // ------------------------------------------------------------------
    // Slew stage, accumulators and committed outputs
    // ------------------------------------------------------------------
    logic [DAC_BITS-1:0] acc [CHANNELS];

`ifdef BHG_JT49_VOL_MIX_EN
    localparam int MIX_W = DAC_BITS + $clog2(CHANNELS + 1);
    logic [MIX_W-1:0] mix_sum;

    always_comb begin
        mix_sum = '0;
        for (int k = 0; k < CHANNELS; k++) mix_sum = mix_sum + MIX_W'(acc[k]);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld     <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) acc[k] <= '0;
`ifdef BHG_JT49_VOL_MIX_EN
            mix        <= '0;
`endif
        end else begin
            s1_vld     <= s1_load;
            dout_valid <= commit;
            for (int k = 0; k < CHANNELS; k++) begin
                if (s1_vld && int'(s1_ch) == k) acc[k] <= slew_step(acc[k], lut_q);
                if (commit) dout[k*DAC_BITS +: DAC_BITS] <= acc[k];
            end
`ifdef BHG_JT49_VOL_MIX_EN
            if (commit) mix <= mix_sum;
`endif
        end
    end

endmodule

// File: tb/tb_bhg_jt49_vol_seq.sv
// ----------------------------------------------------------------------------
// tb_bhg_jt49_vol_seq
//   Self-checking bench for bhg_jt49_vol_seq. It uses three instances:
//     u0: DAC_BITS=8, CHANNELS=3, SLEW=0
//     u1: DAC_BITS=8, CHANNELS=3, SLEW=64
//     u2: DAC_BITS=8, CHANNELS=1, SLEW=0
//   Expected codes come from the dB formula and an arithmetic slew model.
// ----------------------------------------------------------------------------
module tb_bhg_jt49_vol_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        cen0, cen1, cen2;
    logic [14:0] din0, din1;
    logic [4:0]  din2;
    logic        busy0, busy1, busy2;
    logic [23:0] dout0, dout1;
    logic [7:0]  dout2;
    logic        dv0, dv1, dv2;
`ifdef BHG_JT49_VOL_MIX_EN
    logic [9:0]  mix0, mix1;
    logic [8:0]  mix2;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cur1 [3];            // model of u1's slewed channel values

    always #5 clk = ~clk;

    bhg_jt49_vol_seq #(.DAC_BITS(8), .CHANNELS(3), .SLEW(0)) u0 (
        .clk(clk), .rst_n(rst_n), .cen(cen0), .din(din0),
        .busy(busy0), .dout(dout0), .dout_valid(dv0)
`ifdef BHG_JT49_VOL_MIX_EN
        , .mix(mix0)
`endif
    );

    bhg_jt49_vol_seq #(.DAC_BITS(8), .CHANNELS(3), .SLEW(64)) u1 (
        .clk(clk), .rst_n(rst_n), .cen(cen1), .din(din1),
        .busy(busy1), .dout(dout1), .dout_valid(dv1)
`ifdef BHG_JT49_VOL_MIX_EN
        , .mix(mix1)
`endif
    );

    bhg_jt49_vol_seq #(.DAC_BITS(8), .CHANNELS(1), .SLEW(0)) u2 (
        .clk(clk), .rst_n(rst_n), .cen(cen2), .din(din2),
        .busy(busy2), .dout(dout2), .dout_valid(dv2)
`ifdef BHG_JT49_VOL_MIX_EN
        , .mix(mix2)
`endif
    );

    // ---------------- reference model ----------------
    function automatic int lut_model(input int lvl);
        if (lvl == 0) return 0;
        return $rtoi(255.0 * (10.0 ** (-(31 - lvl) * 1.5 / 20.0)) + 0.5);
    endfunction

    function automatic int lvl_of(input logic [14:0] d, input int k);
        return int'(d[5*k +: 5]);
    endfunction

    function automatic int slew_model(input int cur, input int tgt, input int s);
        int d;
        d = tgt - cur;
        if (s == 0 || (d <= s && d >= -s)) return tgt;
        return (d > 0) ? cur + s : cur - s;
    endfunction

    // ---------------- pass helpers (stimulus only) ----------------
    // Pulse cen for one clock (cycle 0) and count clocks until dout_valid (-1 on timeout).
    task automatic pass0(input logic [14:0] d, output int lat, output logic busy_seen);
        din0 = d; cen0 = 1'b1;
        @(posedge clk); #1 cen0 = 1'b0;
        lat = -1; busy_seen = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 1) busy_seen = busy0;
            if (dv0) begin lat = n; break; end
        end
    endtask

    task automatic pass1(input logic [14:0] d, output int lat);
        din1 = d; cen1 = 1'b1;
        @(posedge clk); #1 cen1 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (dv1) begin lat = n; break; end
        end
    endtask

    task automatic pass2(input logic [4:0] d, output int lat);
        din2 = d; cen2 = 1'b1;
        @(posedge clk); #1 cen2 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (dv2) begin lat = n; break; end
        end
    endtask

    // Run one u1 pass, advance the model and compare every channel.
    task automatic slew_pass_check(input logic [14:0] d, input string tag);
        int lat;
        pass1(d, lat);
        n_checks++;
        if (lat !== 5) $display("FAIL %s latency: got %0d expected 5", tag, lat);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            cur1[k] = slew_model(cur1[k], lut_model(lvl_of(d, k)), 64);
            n_checks++;
            if (int'(dout1[8*k +: 8]) !== cur1[k])
                $display("FAIL %s ch%0d: got %0d expected %0d", tag, k, dout1[8*k +: 8], cur1[k]);
            else n_pass++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_checks++;
        if (dout0 !== '0 || dout1 !== '0 || dout2 !== '0)
            $display("FAIL reset dout: got %h/%h/%h expected 0", dout0, dout1, dout2);
        else n_pass++;
        n_checks++;
        if ({dv0, dv1, dv2} !== 3'b000)
            $display("FAIL reset dout_valid: got %b expected 000", {dv0, dv1, dv2});
        else n_pass++;
        n_checks++;
        if ({busy0, busy1, busy2} !== 3'b000)
            $display("FAIL reset busy: got %b expected 000", {busy0, busy1, busy2});
        else n_pass++;
    endtask

    task automatic test_spec_vector();
        int lat;
        logic bs;
        logic [14:0] d;
        int sum;
        d = {5'd0, 5'd30, 5'd31};
        pass0(d, lat, bs);
        n_checks++;
        if (lat !== 5) $display("FAIL vector latency: got %0d expected 5", lat);
        else n_pass++;
        n_checks++;
        if (bs !== 1'b1) $display("FAIL vector busy during pass: got %b expected 1", bs);
        else n_pass++;
        sum = 0;
        for (int k = 0; k < 3; k++) begin
            sum += lut_model(lvl_of(d, k));
            n_checks++;
            if (int'(dout0[8*k +: 8]) !== lut_model(lvl_of(d, k)))
                $display("FAIL vector ch%0d: got %0d expected %0d", k, dout0[8*k +: 8], lut_model(lvl_of(d, k)));
            else n_pass++;
        end
`ifdef BHG_JT49_VOL_MIX_EN
        n_checks++;
        if (int'(mix0) !== sum) $display("FAIL vector mix: got %0d expected %0d", mix0, sum);
        else n_pass++;
`endif
        @(posedge clk); #1;
        n_checks++;
        if (busy0 !== 1'b0 || dv0 !== 1'b0)
            $display("FAIL vector after done: busy=%b valid=%b expected 0/0", busy0, dv0);
        else n_pass++;
        // dout holds between passes
        n_checks++;
        if (int'(dout0[15:8]) !== lut_model(30))
            $display("FAIL vector hold ch1: got %0d expected %0d", dout0[15:8], lut_model(30));
        else n_pass++;
        d = {5'd31, 5'd31, 5'd31};
        pass0(d, lat, bs);
        n_checks++;
        if (dout0 !== {3{8'(lut_model(31))}})
            $display("FAIL vector full scale: got %h expected all %0d", dout0, lut_model(31));
        else n_pass++;
`ifdef BHG_JT49_VOL_MIX_EN
        n_checks++;
        if (int'(mix0) !== 3 * lut_model(31))
            $display("FAIL vector mix full scale: got %0d expected %0d", mix0, 3 * lut_model(31));
        else n_pass++;
`endif
    endtask

    task automatic test_lut_sweep();
        int lat;
        for (int l = 0; l < 32; l++) begin
            pass2(5'(l), lat);
            n_checks++;
            if (lat !== 3) $display("FAIL sweep latency lvl%0d: got %0d expected 3", l, lat);
            else n_pass++;
            n_checks++;
            if (int'(dout2) !== lut_model(l))
                $display("FAIL sweep lvl%0d: got %0d expected %0d", l, dout2, lut_model(l));
            else n_pass++;
            if (l == 1) begin
                n_checks++;
                if (dout2 !== 8'd1) $display("FAIL sweep lut1: got %0d expected 1", dout2);
                else n_pass++;
            end
        end
    endtask

    task automatic test_slew();
        for (int p = 0; p < 5; p++) slew_pass_check({3{5'd31}}, "slew up");
`ifdef BHG_JT49_VOL_MIX_EN
        n_checks++;
        if (int'(mix1) !== cur1[0] + cur1[1] + cur1[2])
            $display("FAIL slew mix: got %0d expected %0d", mix1, cur1[0] + cur1[1] + cur1[2]);
        else n_pass++;
`endif
        for (int p = 0; p < 4; p++) slew_pass_check({3{5'd0}}, "slew down");
    endtask

    task automatic test_random_slew();
        for (int p = 0; p < 24; p++) slew_pass_check(15'($urandom), "slew random");
    endtask

    task automatic test_pending();
        logic [14:0] a, b, c;
        int vcount;
        a = 15'($urandom); b = 15'($urandom); c = 15'($urandom);
        vcount = 0;
        for (int cy = 0; cy < 16; cy++) begin
            cen0 = (cy == 0 || cy == 2 || cy == 3);
            din0 = (cy == 0) ? a : ((cy <= 5) ? b : c);
            @(posedge clk); #1;
            if (dv0) begin
                vcount++;
                n_checks++;
                if (cy != 5 && cy != 10) $display("FAIL pending valid cycle: got %0d expected 5 or 10", cy);
                else n_pass++;
                for (int k = 0; k < 3; k++) begin
                    n_checks++;
                    if (int'(dout0[8*k +: 8]) !== lut_model(lvl_of((cy == 5) ? a : b, k)))
                        $display("FAIL pending data cy%0d ch%0d: got %0d expected %0d", cy, k,
                                 dout0[8*k +: 8], lut_model(lvl_of((cy == 5) ? a : b, k)));
                    else n_pass++;
                end
            end
        end
        cen0 = 1'b0;
        n_checks++;
        if (vcount !== 2) $display("FAIL pending pass count: got %0d expected 2", vcount);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [14:0] hist [20];
        int vcount;
        vcount = 0;
        for (int cy = 0; cy < 20; cy++) begin
            hist[cy] = 15'($urandom);
            din0 = hist[cy];
            cen0 = (cy <= 10);
            @(posedge clk); #1;
            if (dv0) begin
                vcount++;
                n_checks++;
                if (cy != 5 && cy != 10 && cy != 15)
                    $display("FAIL b2b valid cycle: got %0d expected 5/10/15", cy);
                else n_pass++;
                for (int k = 0; k < 3; k++) begin
                    n_checks++;
                    if (cy >= 5 && int'(dout0[8*k +: 8]) !== lut_model(lvl_of(hist[cy-5], k)))
                        $display("FAIL b2b data cy%0d ch%0d: got %0d expected %0d", cy, k,
                                 dout0[8*k +: 8], lut_model(lvl_of(hist[cy-5], k)));
                    else n_pass++;
                end
            end
        end
        cen0 = 1'b0;
        n_checks++;
        if (vcount !== 3) $display("FAIL b2b pass count: got %0d expected 3", vcount);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic bs;
        int vcount;
        logic [14:0] d;
        din0 = {5'd31, 5'd28, 5'd20};
        cen0 = 1'b1;
        @(posedge clk); #1 cen0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dout0 !== '0 || busy0 !== 1'b0 || dv0 !== 1'b0)
            $display("FAIL midreset: dout=%h busy=%b valid=%b expected 0/0/0", dout0, busy0, dv0);
        else n_pass++;
        n_checks++;
        if (dout1 !== '0) $display("FAIL midreset u1 dout: got %h expected 0", dout1);
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) cur1[k] = 0;
        vcount = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (dv0 || busy0) vcount++;
        end
        n_checks++;
        if (vcount !== 0) $display("FAIL midreset stray activity: got %0d cycles expected 0", vcount);
        else n_pass++;
        d = 15'($urandom);
        pass0(d, lat, bs);
        n_checks++;
        if (lat !== 5) $display("FAIL midreset latency: got %0d expected 5", lat);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (int'(dout0[8*k +: 8]) !== lut_model(lvl_of(d, k)))
                $display("FAIL midreset ch%0d: got %0d expected %0d", k, dout0[8*k +: 8], lut_model(lvl_of(d, k)));
            else n_pass++;
        end
        // The slew accumulators restart from zero.
        slew_pass_check({3{5'd31}}, "midreset slew");
    endtask

    initial begin
        rst_n = 1'b0;
        cen0 = 1'b0; cen1 = 1'b0; cen2 = 1'b0;
        din0 = '0;   din1 = '0;   din2 = '0;
        for (int k = 0; k < 3; k++) cur1[k] = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_spec_vector();
        test_lut_sweep();
        test_slew();
        test_random_slew();
        test_pending();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
